// File: rtl/wb_sram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge_pkg
// Shared definitions for the Wishbone-to-SRAM-controller bridge:
//   - memory controller request codes (none / read / write)
//   - default SRAM word-address width
//   - 3-bit bridge FSM state encodings
// ---------------------------------------------------------------------------
package wb_sram_bridge_pkg;

   // Request codes understood by the SRAM memory controller
   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_READ  = 2'b01;
   localparam logic [1:0] MEM_OP_WRITE = 2'b11;

   // Default SRAM word-address width
   localparam int KICP_SRAM_AWIDTH = 10;

   // Width of the hung-operation watchdog counter
   localparam int TIMEOUT_CNT_W = 8;

   // Bridge FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_WRITE  = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_ACK    = 3'd5,
      ST_ERR    = 3'd6
   } bridgeState_e;

endpackage

// File: rtl/wb_sram_byte_merge.sv
// ---------------------------------------------------------------------------
// wb_sram_byte_merge
// Combinational byte merge used to emulate byte enables on a controller that
// only writes full words. Byte i of the result comes from the write word when
// sel_i[i] is set, otherwise from the word just read back from SRAM.
// Ports:
//   rdata_i  [31:0] word read from SRAM
//   wdata_i  [31:0] bus write data
//   sel_i    [3:0]  bus byte selects
//   merged_o [31:0] word to write back
// ---------------------------------------------------------------------------
module wb_sram_byte_merge (
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] merged_o
);

   // Start from the stored word and overlay every selected byte
   always_comb begin
      merged_o = rdata_i;
      for (int i = 0; i < 4; i++) begin
         if (sel_i[i]) begin
            merged_o[i*8 +: 8] = wdata_i[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// wb_sram_bridge
// Wishbone classic slave that converts bus cycles into the request/done
// handshake of the SRAM memory controller. Partial writes are done as a
// read-modify-write; a watchdog ends hung operations with an error.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i  Wishbone cycle, strobe, write enable
//   wbs_sel_i [3:0]       byte selects
//   wbs_adr_i [31:0]      byte address
//   wbs_dat_i [31:0]      write data
//   wbs_ack_o, wbs_err_o  one-cycle acknowledge / timeout error
//   wbs_dat_o [31:0]      read data, held until the next read completes
//   mem_op [1:0]          controller request (00 none, 01 read, 11 write)
//   mem_addr [AWIDTH-1:0] controller word address
//   mem_wdata [31:0]      controller write word
//   mem_opdone            controller completion pulse
//   mem_rdata [31:0]      controller read word, valid with mem_opdone
// ---------------------------------------------------------------------------
module wb_sram_bridge
   import wb_sram_bridge_pkg::*;
#(
   parameter int          AWIDTH    = KICP_SRAM_AWIDTH,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic [31:0]       wbs_dat_o,
   output logic [1:0]        mem_op,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_opdone,
   input  logic [31:0]       mem_rdata
);

   localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT - 1);

   bridgeState_e             state_q, state_d;
   logic [1:0]               memOp_q, memOp_d;
   logic [AWIDTH-1:0]        memAddr_q, memAddr_d;
   logic [31:0]              memWdata_q, memWdata_d;
   logic [31:0]              wrData_q, wrData_d;
   logic [3:0]               sel_q, sel_d;
   logic [31:0]              datOut_q, datOut_d;
   logic                     ack_q, ack_d;
   logic                     err_q, err_d;
   logic [TIMEOUT_CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;

   logic                     hit;
   logic                     waiting;
   logic [31:0]              mergedWord;
   logic                     unusedAdrBits;

   // Byte-lane bits of the address never reach the word-addressed controller
   assign unusedAdrBits = ^wbs_adr_i[1:0];

   // A request is ours only when the upper address bits match the window
   assign hit = wbs_cyc_i && wbs_stb_i &&
                (wbs_adr_i[31:AWIDTH+2] == BASE_ADDR[31:AWIDTH+2]);

   // Waiting on the controller means a request is actually on the wire; the
   // one-cycle gap inside a read-modify-write has mem_op at none and is excluded
   assign waiting = (state_q inside {ST_READ, ST_WRITE, ST_RMW_RD, ST_RMW_WR}) &&
                    (memOp_q != MEM_OP_NONE);

   wb_sram_byte_merge u_merge (
      .rdata_i  (mem_rdata),
      .wdata_i  (wrData_q),
      .sel_i    (sel_q),
      .merged_o (mergedWord)
   );

   // State and output registers; everything the bus or controller sees
   // comes straight from a flop
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         memOp_q      <= MEM_OP_NONE;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         wrData_q     <= '0;
         sel_q        <= '0;
         datOut_q     <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         timeoutCnt_q <= '0;
      end else begin
         state_q      <= state_d;
         memOp_q      <= memOp_d;
         memAddr_q    <= memAddr_d;
         memWdata_q   <= memWdata_d;
         wrData_q     <= wrData_d;
         sel_q        <= sel_d;
         datOut_q     <= datOut_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         timeoutCnt_q <= timeoutCnt_d;
      end
   end

   // Next-state logic. mem_op is dropped on the same edge that samples
   // mem_opdone so the controller never sees the request twice. The ack is
   // decided on the edge entering ACK so a master that already left the
   // cycle gets no acknowledge.
   always_comb begin
      state_d      = state_q;
      memOp_d      = memOp_q;
      memAddr_d    = memAddr_q;
      memWdata_d   = memWdata_q;
      wrData_d     = wrData_q;
      sel_d        = sel_q;
      datOut_d     = datOut_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      timeoutCnt_d = timeoutCnt_q;

      case (state_q)
         ST_IDLE: begin
            if (hit) begin
               memAddr_d    = wbs_adr_i[AWIDTH+1:2];
               wrData_d     = wbs_dat_i;
               sel_d        = wbs_sel_i;
               timeoutCnt_d = '0;
               if (!wbs_we_i) begin
                  state_d = ST_READ;
                  memOp_d = MEM_OP_READ;
               end else if (wbs_sel_i == 4'hF) begin
                  state_d    = ST_WRITE;
                  memOp_d    = MEM_OP_WRITE;
                  memWdata_d = wbs_dat_i;
               end else if (wbs_sel_i == 4'h0) begin
                  state_d = ST_ACK;
                  ack_d   = wbs_cyc_i;
               end else begin
                  state_d = ST_RMW_RD;
                  memOp_d = MEM_OP_READ;
               end
            end
         end
         ST_READ: begin
            if (mem_opdone) begin
               datOut_d = mem_rdata;
               memOp_d  = MEM_OP_NONE;
               state_d  = ST_ACK;
               ack_d    = wbs_cyc_i;
            end
         end
         ST_RMW_RD: begin
            if (mem_opdone) begin
               memWdata_d = mergedWord;
               memOp_d    = MEM_OP_NONE;
               state_d    = ST_RMW_WR;
            end
         end
         ST_RMW_WR: begin
            if (memOp_q == MEM_OP_NONE) begin
               memOp_d      = MEM_OP_WRITE;
               timeoutCnt_d = '0;
            end else if (mem_opdone) begin
               memOp_d = MEM_OP_NONE;
               state_d = ST_ACK;
               ack_d   = wbs_cyc_i;
            end
         end
         ST_WRITE: begin
            if (mem_opdone) begin
               memOp_d = MEM_OP_NONE;
               state_d = ST_ACK;
               ack_d   = wbs_cyc_i;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            memOp_d = MEM_OP_NONE;
         end
      endcase

      // Watchdog: abandon the request once it has been outstanding for
      // TIMEOUT cycles without a completion pulse
      if (waiting && !mem_opdone) begin
         if (timeoutCnt_q == TIMEOUT_LAST) begin
            memOp_d = MEM_OP_NONE;
            state_d = ST_ERR;
            err_d   = 1'b1;
         end else begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
         end
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign wbs_dat_o = datOut_q;
   assign mem_op    = memOp_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_bridge
// Self-checking bench for wb_sram_bridge. A behavioural SRAM controller
// answers requests after a chosen latency and logs every request it sees;
// a word-array reference memory holds what SRAM should contain.
// ---------------------------------------------------------------------------
module tb_wb_sram_bridge;

   localparam int          AW       = 10;
   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam int          TB_TMO   = 8;
   localparam logic [1:0]  OP_NONE  = 2'b00;
   localparam logic [1:0]  OP_READ  = 2'b01;
   localparam logic [1:0]  OP_WRITE = 2'b11;

   logic          clk;
   logic          reset;
   logic          wbs_cyc_i;
   logic          wbs_stb_i;
   logic          wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_adr_i;
   logic [31:0]   wbs_dat_i;
   logic          wbs_ack_o;
   logic          wbs_err_o;
   logic [31:0]   wbs_dat_o;
   logic [1:0]    mem_op;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_opdone;
   logic [31:0]   mem_rdata;

   typedef struct {
      logic [1:0]  op;
      logic [9:0]  addr;
      logic [31:0] wdata;
      int          issueCycle;
      int          doneCycle;
      bit          held;
   } opRec_t;

   opRec_t      opLog[$];
   logic [31:0] refMem[1024];
   logic [31:0] lastRead;
   int          cycleCnt = 0;
   int          respLatency = 3;
   bit          noResponse = 0;
   int          strayCount = 0;
   int          checkCount = 0;
   int          failCount = 0;

   int          modelCountdown;
   int          modelIdx;
   int          strayServed;
   bit          modelBusy;
   bit          modelPulsing;

   wb_sram_bridge #(
      .AWIDTH    (AW),
      .BASE_ADDR (BASE),
      .TIMEOUT   (TB_TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_err_o  (wbs_err_o),
      .wbs_dat_o  (wbs_dat_o),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_opdone (mem_opdone),
      .mem_rdata  (mem_rdata)
   );

   // Free-running clock and cycle counter used for latency checks
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Behavioural memory controller: picks up a request, answers after
   // respLatency cycles with a one-cycle done pulse, and forgets a request
   // that is withdrawn before it answers
   initial begin
      opRec_t rec;
      modelBusy = 0;
      modelPulsing = 0;
      modelCountdown = 0;
      modelIdx = 0;
      strayServed = 0;
      mem_opdone = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (modelPulsing) begin
            mem_opdone = 1'b0;
            modelPulsing = 0;
         end else if (strayCount != strayServed) begin
            strayServed++;
            mem_rdata = 32'hBAD0_BAD0;
            mem_opdone = 1'b1;
            modelPulsing = 1;
         end else if (modelBusy) begin
            if (mem_op == OP_NONE) begin
               modelBusy = 0;
            end else begin
               if (modelCountdown > 0) modelCountdown--;
               if (modelCountdown == 0 && !noResponse) begin
                  opLog[modelIdx].held = (mem_op == opLog[modelIdx].op) &&
                                         (mem_addr == opLog[modelIdx].addr);
                  opLog[modelIdx].wdata = mem_wdata;
                  opLog[modelIdx].doneCycle = cycleCnt + 1;
                  if (mem_op == OP_READ) mem_rdata = refMem[mem_addr];
                  mem_opdone = 1'b1;
                  modelPulsing = 1;
                  modelBusy = 0;
               end
            end
         end else if (mem_op != OP_NONE) begin
            rec.op = mem_op;
            rec.addr = mem_addr;
            rec.wdata = mem_wdata;
            rec.issueCycle = cycleCnt;
            rec.doneCycle = 0;
            rec.held = 0;
            opLog.push_back(rec);
            modelIdx = opLog.size() - 1;
            modelCountdown = respLatency;
            modelBusy = 1;
         end
      end
   end

   // Count one comparison and report it when observed and expected differ
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Reference write rule: each selected byte replaces the stored byte
   function automatic logic [31:0] mergeBytes(input logic [31:0] stored,
                                              input logic [31:0] data,
                                              input logic [3:0] sel);
      logic [31:0] res;
      res = stored;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

   task automatic dropBus();
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic driveBus(input bit isWrite, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = isWrite;
      wbs_adr_i = addr;
      wbs_sel_i = sel;
      wbs_dat_i = data;
   endtask

   // One complete bus transaction that is expected to be acknowledged, with
   // the controller traffic, timing and data it should cause
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] data,
                                input int latency);
      int          base;
      int          word;
      int          nOps;
      int          n;
      int          issueCycle;
      int          ackCycle;
      bit          gotAck;
      bit          gotErr;
      logic [1:0]  expOp[2];
      logic [31:0] expData[2];
      logic [31:0] expWord;

      word = int'(addr[11:2]);
      respLatency = latency;
      base = opLog.size();
      expWord = isWrite ? mergeBytes(refMem[word], data, sel) : refMem[word];
      expOp[0] = OP_READ;
      expOp[1] = OP_WRITE;
      expData[0] = data;
      expData[1] = expWord;
      if (!isWrite) nOps = 1;
      else if (sel == 4'hF) begin
         nOps = 1;
         expOp[0] = OP_WRITE;
      end else if (sel == 4'h0) nOps = 0;
      else nOps = 2;

      @(negedge clk);
      driveBus(isWrite, addr, sel, data);
      issueCycle = cycleCnt + 1;
      gotAck = 0;
      gotErr = 0;
      ackCycle = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) checkOutput("memAddr", 32'(mem_addr), 32'(word));
         if (wbs_ack_o || wbs_err_o) begin
            gotAck = wbs_ack_o;
            gotErr = wbs_err_o;
            ackCycle = cycleCnt;
            break;
         end
      end
      dropBus();

      checkOutput("ack", 32'(gotAck), 32'd1);
      checkOutput("noErr", 32'(gotErr), 32'd0);
      checkOutput("opIdleAtAck", 32'(mem_op), 32'(OP_NONE));
      n = opLog.size() - base;
      checkOutput("opCount", 32'(n), 32'(nOps));
      for (int k = 0; k < nOps && k < n; k++) begin
         checkOutput("opKind", 32'(opLog[base+k].op), 32'(expOp[k]));
         checkOutput("opAddr", 32'(opLog[base+k].addr), 32'(word));
         checkOutput("opHeld", 32'(opLog[base+k].held), 32'd1);
         if (expOp[k] == OP_WRITE) checkOutput("opWdata", opLog[base+k].wdata, expData[k]);
      end
      if (nOps == 0) checkOutput("ackNoAccess", 32'(ackCycle), 32'(issueCycle));
      if (nOps > 0 && n >= nOps)
         checkOutput("ackTiming", 32'(ackCycle), 32'(opLog[base+nOps-1].doneCycle));
      if (nOps == 2 && n >= 2)
         checkOutput("rmwGap", 32'(opLog[base+1].issueCycle), 32'(opLog[base].doneCycle + 1));
      if (!isWrite) begin
         checkOutput("rdData", wbs_dat_o, expWord);
         lastRead = expWord;
      end else begin
         checkOutput("datHold", wbs_dat_o, lastRead);
         refMem[word] = expWord;
      end
   endtask

   initial begin
      int          base;
      int          issueCycle;
      int          evCycle;
      bit          gotAck;
      bit          gotErr;
      bit          anyAct;
      bit          anyAck;
      logic [31:0] rnd;
      logic [3:0]  sel;

      reset = 1'b1;
      dropBus();
      wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h0;
      wbs_dat_i = 32'h0;
      lastRead = 32'h0;
      for (int i = 0; i < 1024; i++) refMem[i] = $urandom;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("rstAck", 32'(wbs_ack_o), 32'd0);
      checkOutput("rstErr", 32'(wbs_err_o), 32'd0);
      checkOutput("rstDat", wbs_dat_o, 32'h0);
      checkOutput("rstOp", 32'(mem_op), 32'(OP_NONE));
      checkOutput("rstAddr", 32'(mem_addr), 32'h0);
      checkOutput("rstWdata", mem_wdata, 32'h0);

      // Directed read, full write, byte write and empty-select write
      refMem[4] = 32'hDEAD_BEEF;
      applyStimulus(1'b0, BASE + 32'h10, 4'hF, 32'h0, 3);
      checkOutput("readWord", wbs_dat_o, 32'hDEAD_BEEF);
      applyStimulus(1'b1, BASE + 32'h1C, 4'hF, 32'h1234_5678, 2);
      refMem[9] = 32'hAABB_CCDD;
      base = opLog.size();
      applyStimulus(1'b1, BASE + 32'h24, 4'b0101, 32'h1122_3344, 2);
      if (opLog.size() >= base + 2) checkOutput("rmwWord", opLog[base+1].wdata, 32'hAA22_CC44);
      else checkOutput("rmwOps", 32'(opLog.size() - base), 32'd2);
      applyStimulus(1'b1, BASE + 32'h28, 4'h0, 32'hFFFF_FFFF, 1);

      // Hung controller: error after TB_TMO cycles, then a stray done pulse
      noResponse = 1;
      respLatency = 2;
      @(negedge clk);
      driveBus(1'b0, BASE + 32'h14, 4'hF, 32'h0);
      issueCycle = cycleCnt + 1;
      gotAck = 0;
      gotErr = 0;
      evCycle = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (wbs_ack_o || wbs_err_o) begin
            gotAck = wbs_ack_o;
            gotErr = wbs_err_o;
            evCycle = cycleCnt;
            break;
         end
      end
      dropBus();
      checkOutput("tmoErr", 32'(gotErr), 32'd1);
      checkOutput("tmoNoAck", 32'(gotAck), 32'd0);
      checkOutput("tmoCycle", 32'(evCycle), 32'(issueCycle + TB_TMO));
      checkOutput("tmoOpIdle", 32'(mem_op), 32'(OP_NONE));
      @(negedge clk);
      checkOutput("tmoErrPulse", 32'(wbs_err_o), 32'd0);
      checkOutput("tmoDatHold", wbs_dat_o, lastRead);
      noResponse = 0;
      strayCount++;
      anyAct = 0;
      repeat (5) begin
         @(negedge clk);
         if (wbs_ack_o || wbs_err_o || mem_op != OP_NONE) anyAct = 1;
      end
      checkOutput("strayIgnored", 32'(anyAct), 32'd0);
      applyStimulus(1'b0, BASE + 32'h14, 4'hF, 32'h0, 2);

      // Master abandons a read: controller still completes, no ack
      respLatency = 3;
      base = opLog.size();
      @(negedge clk);
      driveBus(1'b0, BASE + 32'h30, 4'hF, 32'h0);
      @(negedge clk);
      dropBus();
      anyAck = 0;
      anyAct = 0;
      repeat (10) begin
         @(negedge clk);
         if (wbs_ack_o) anyAck = 1;
         if (wbs_err_o) anyAct = 1;
      end
      checkOutput("abortNoAck", 32'(anyAck), 32'd0);
      checkOutput("abortNoErr", 32'(anyAct), 32'd0);
      checkOutput("abortOps", 32'(opLog.size() - base), 32'd1);
      if (opLog.size() > base)
         checkOutput("abortDone", 32'(opLog[base].doneCycle != 0), 32'd1);
      checkOutput("abortDat", wbs_dat_o, refMem[12]);
      lastRead = refMem[12];

      // Address outside the window is ignored completely
      base = opLog.size();
      @(negedge clk);
      driveBus(1'b0, 32'h4000_0010, 4'hF, 32'h0);
      anyAct = 0;
      repeat (6) begin
         @(negedge clk);
         if (wbs_ack_o || wbs_err_o || mem_op != OP_NONE) anyAct = 1;
      end
      dropBus();
      checkOutput("missIgnored", 32'(anyAct), 32'd0);
      checkOutput("missOps", 32'(opLog.size() - base), 32'd0);

      // Reset while a write is outstanding
      respLatency = 6;
      @(negedge clk);
      driveBus(1'b1, BASE + 32'h40, 4'hF, 32'h5555_AAAA);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstMidOp", 32'(mem_op), 32'(OP_WRITE));
      dropBus();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rstMidOpClr", 32'(mem_op), 32'(OP_NONE));
      checkOutput("rstMidAck", 32'(wbs_ack_o), 32'd0);
      checkOutput("rstMidErr", 32'(wbs_err_o), 32'd0);
      checkOutput("rstMidDat", wbs_dat_o, 32'h0);
      checkOutput("rstMidAddr", 32'(mem_addr), 32'h0);
      checkOutput("rstMidWdata", mem_wdata, 32'h0);
      lastRead = 32'h0;
      applyStimulus(1'b0, BASE + 32'h40, 4'hF, 32'h0, 2);

      // Randomized mix of reads, full writes, byte writes and empty writes
      for (int t = 0; t < 40; t++) begin
         rnd = $urandom;
         case ($urandom_range(0, 3))
            0: sel = 4'hF;
            1: sel = 4'h0;
            default: sel = 4'($urandom_range(1, 14));
         endcase
         applyStimulus(rnd[0], BASE + 32'($urandom_range(0, 15) * 4), sel,
                       $urandom, int'($urandom_range(1, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
